i2c_slave_regfile: RTL

- Parametrised I2C target (slave) with an internal byte-wide register file, 7-bit address match, a register pointer, and multi-byte burst reads/writes with pointer auto-increment.
- Adds over the previous-generation slave: input synchronisers, repeated-START handling, NACK on address mismatch, and a fabric-side read port plus write-notify strobe.
- Sits between the board I2C pins (through IOBUF: _i/_o/_t) and local logic consuming configuration registers.

---
 rtl/i2c_slave_regfile.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// i2c_slave_regfile : I2C target with byte register file, pointer, bursts
// Rev 1.0
// ============================================================================
module i2c_slave_regfile #(
  parameter logic [6:0] I2C_ADR     = 7'h30,
  parameter int         REG_ADDR_W  = 8,
  parameter int         SYNC_STAGES = 2,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  SDA_i,
  input  logic                  SCL_i,
  output logic                  SDA_o,
  output logic                  SDA_t,
  output logic                  SCL_o,
  output logic                  SCL_t,
  input  logic [REG_ADDR_W-1:0] host_addr,
  output logic [7:0]            host_rdata,
  output logic                  wr_strobe,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic [REG_ADDR_W-1:0] reg_ptr
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK
  } state_e;

  state_e                state_q, state_d;
  logic [SYNC_N-1:0]     sda_sync_q, scl_sync_q;
  logic                  sda_prev_q, scl_prev_q;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  rw_q, rw_d;
  logic                  sda_t_q, sda_t_d;
  logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            host_rdata_q;
  logic [7:0]            regs_q [NUM_REGS];

  logic                  w_sda_s, w_scl_s;
  logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]            w_rx_byte;
  logic [REG_ADDR_W-1:0] w_ptr_inc;
  logic                  w_wr_en;

  assign w_sda_s    = sda_sync_q[SYNC_N-1];
  assign w_scl_s    = scl_sync_q[SYNC_N-1];
  assign w_scl_rise = w_scl_s & ~scl_prev_q;
  assign w_scl_fall = ~w_scl_s & scl_prev_q;
  assign w_start    = w_scl_s & scl_prev_q & sda_prev_q & ~w_sda_s;
  assign w_stop     = w_scl_s & scl_prev_q & ~sda_prev_q & w_sda_s;
  assign w_rx_byte  = {shift_q[6:0], w_sda_s};
  assign w_ptr_inc  = AUTO_INC ? ptr_q + REG_ADDR_W'(1) : ptr_q;

  // Synchronisers reset high so an idle bus never looks like a START
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sda_sync_q <= '1;
      scl_sync_q <= '1;
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
    end else begin
      sda_sync_q <= {sda_sync_q[SYNC_N-2:0], SDA_i};
      scl_sync_q <= {scl_sync_q[SYNC_N-2:0], SCL_i};
      sda_prev_q <= w_sda_s;
      scl_prev_q <= w_scl_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      sda_t_q     <= 1'b1;
      ptr_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      sda_t_q     <= sda_t_d;
      ptr_q       <= ptr_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      host_rdata_q <= 8'h00;
    end else begin
      if (w_wr_en) regs_q[ptr_q] <= w_rx_byte;
      host_rdata_q <= regs_q[host_addr];
    end
  end

  // ACK states: first SCL fall pulls SDA low, the second releases and moves on
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    sda_t_d     = sda_t_q;
    ptr_d       = ptr_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    w_wr_en     = 1'b0;
    if (w_start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_t_d   = 1'b1;
    end else if (w_stop) begin
      state_d = ST_IDLE;
      sda_t_d = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (w_scl_rise) begin
            shift_d   = w_rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR) begin
                rw_d    = w_rx_byte[0];
                state_d = (w_rx_byte[7:1] == I2C_ADR) ? ST_ADDR_ACK : ST_IDLE;
              end else if (state_q == ST_PTR) begin
                ptr_d   = REG_ADDR_W'(w_rx_byte);
                state_d = ST_PTR_ACK;
              end else begin
                w_wr_en     = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = w_rx_byte;
                ptr_d       = w_ptr_inc;
                state_d     = ST_WR_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (w_scl_fall) begin
            if (sda_t_q) begin
              sda_t_d = 1'b0;
            end else begin
              sda_t_d   = 1'b1;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                sda_t_d   = regs_q[ptr_q][7];
                shift_d   = {regs_q[ptr_q][6:0], 1'b0};
                bit_cnt_d = 4'd1;
                state_d   = ST_RD_DATA;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WR_DATA;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (w_scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_t_d   = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end else begin
              sda_t_d   = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda_s) begin
              ptr_d     = w_ptr_inc;
              shift_d   = regs_q[w_ptr_inc];
              bit_cnt_d = '0;
              state_d   = ST_RD_DATA;
            end else begin
              sda_t_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA_o      = 1'b0;
  assign SDA_t      = sda_t_q;
  assign SCL_o      = 1'b0;
  assign SCL_t      = 1'b1;
  assign host_rdata = host_rdata_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != ST_IDLE);
  assign reg_ptr    = ptr_q;

endmodule
`default_nettype wire
